// File: rtl/limit_regfile.sv
// Password-guarded limit table: flop-based entries with per-entry reset defaults,
// a registered read port, and an unlock/lockout controller gating writes.
module limit_regfile #(
  parameter int                     WIDTH          = 4,
  parameter int                     DEPTH          = 4,
  parameter int                     ADDR_W         = 2,
  parameter logic [DEPTH*WIDTH-1:0] INIT           = 16'h68AC,
  parameter int                     UNLOCK_CYCLES  = 16,
  parameter int                     MAX_FAIL       = 3,
  parameter int                     LOCKOUT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              unlock_req,
  input  logic [WIDTH-1:0]  key,
  input  logic              lock_req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_err,
  output logic              unlock_ok,
  output logic              unlock_fail,
  output logic              unlocked,
  output logic              alarm
);

  localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int FAIL_W  = (MAX_FAIL > 0) ? $clog2(MAX_FAIL + 1) : 1;
  localparam int SPAN    = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_UNLOCKED = 2'd1,
    S_LOCKOUT  = 2'd2
  } state_t;

  // One bit per encodable address: set where the address maps to a real entry.
  function automatic logic [SPAN-1:0] addr_mask();
    logic [SPAN-1:0] m;
    m = '0;
    for (int i = 0; i < SPAN; i++) m[i] = (i < DEPTH);
    return m;
  endfunction

  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
    return (v >= FAIL_W'(MAX_FAIL)) ? v : v + FAIL_W'(1);
  endfunction

  localparam logic [SPAN-1:0] ADDR_OK = addr_mask();

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_err_q, rd_err_d;
  logic                wr_err_q, wr_err_d;
  logic                unlock_ok_q, unlock_ok_d;
  logic                unlock_fail_q, unlock_fail_d;

  logic                wr_ok;
  logic                rd_ok;
  logic [WIDTH-1:0]    rd_word;
  logic [FAIL_W-1:0]   fail_inc;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    fail_cnt_d    = fail_cnt_q;
    mem_d         = mem_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    rd_err_d      = 1'b0;
    wr_err_d      = 1'b0;
    unlock_ok_d   = 1'b0;
    unlock_fail_d = 1'b0;
    rd_word       = '0;
    fail_inc      = sat_inc(fail_cnt_q);

    // Read port samples memory before this edge's write, so same-address
    // read/write returns the old word.
    rd_ok = ADDR_OK[rd_addr];
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_word = mem_q[i];
    end
    if (rd_en) begin
      rd_valid_d = 1'b1;
      rd_err_d   = !rd_ok;
      rd_data_d  = rd_ok ? rd_word : '0;
    end

    // lock_req wins over a same-cycle write.
    wr_ok = wr_en && (state_q == S_UNLOCKED) && !lock_req && ADDR_OK[wr_addr];
    if (wr_en && !wr_ok) wr_err_d = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (wr_addr == ADDR_W'(i))) mem_d[i] = wr_data;
    end

    unique case (state_q)
      S_LOCKED: begin
        if (unlock_req) begin
          if (key == mem_q[0]) begin
            state_d     = S_UNLOCKED;
            timer_d     = TMR_W'(UNLOCK_CYCLES);
            fail_cnt_d  = '0;
            unlock_ok_d = 1'b1;
          end else begin
            fail_cnt_d    = fail_inc;
            unlock_fail_d = 1'b1;
            if (fail_inc == FAIL_W'(MAX_FAIL)) begin
              state_d = S_LOCKOUT;
              timer_d = TMR_W'(LOCKOUT_CYCLES);
            end
          end
        end
      end
      S_UNLOCKED: begin
        if (lock_req) begin
          state_d = S_LOCKED;
          timer_d = '0;
        end else if (wr_ok) begin
          timer_d = TMR_W'(UNLOCK_CYCLES);
        end else if (timer_q <= TMR_W'(1)) begin
          state_d = S_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_LOCKOUT: begin
        if (timer_q <= TMR_W'(1)) begin
          state_d    = S_LOCKED;
          timer_d    = '0;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d    = S_LOCKED;
        timer_d    = '0;
        fail_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_LOCKED;
      timer_q       <= '0;
      fail_cnt_q    <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_err_q      <= 1'b0;
      wr_err_q      <= 1'b0;
      unlock_ok_q   <= 1'b0;
      unlock_fail_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT[i*WIDTH +: WIDTH];
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      fail_cnt_q    <= fail_cnt_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_err_q      <= rd_err_d;
      wr_err_q      <= wr_err_d;
      unlock_ok_q   <= unlock_ok_d;
      unlock_fail_q <= unlock_fail_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_err      = rd_err_q;
  assign wr_err      = wr_err_q;
  assign unlock_ok   = unlock_ok_q;
  assign unlock_fail = unlock_fail_q;
  assign unlocked    = (state_q == S_UNLOCKED);
  assign alarm       = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_limit_regfile.sv
// Self-checking bench for limit_regfile: scoreboard for the read port plus
// directed checks of the unlock/lockout controller and write gating.
module tb_limit_regfile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       rd_err;
  logic       unlock_req;
  logic [3:0] key;
  logic       lock_req;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_err;
  logic       unlock_ok;
  logic       unlock_fail;
  logic       unlocked;
  logic       alarm;

  limit_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err),
    .unlock_req(unlock_req), .key(key), .lock_req(lock_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .unlock_ok(unlock_ok), .unlock_fail(unlock_fail),
    .unlocked(unlocked), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] model_mem [4];
  logic [4:0] sb_q [$];
  logic [4:0] sb_item;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_mem[0] = 4'b1100;
    model_mem[1] = 4'b1010;
    model_mem[2] = 4'b1000;
    model_mem[3] = 4'b0110;
  endtask

  // One clock: queue expected read result, advance past the edge, clear
  // strobes, then score the read port.
  task automatic tick();
    logic had_read;
    had_read = rd_en;
    if (rd_en) sb_q.push_back({1'b0, model_mem[rd_addr]});
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0; unlock_req = 1'b0; lock_req = 1'b0;
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, had_read});
    if (rd_valid && sb_q.size() > 0) begin
      sb_item = sb_q.pop_front();
      chk("rd_data", {28'd0, rd_data}, {28'd0, sb_item[3:0]});
      chk("rd_err", {31'd0, rd_err}, {31'd0, sb_item[4]});
    end
  endtask

  task automatic do_read(input logic [1:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
  endtask

  task automatic do_unlock(input logic [3:0] k);
    unlock_req = 1'b1; key = k;
    tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    sb_q.delete();
    model_reset();
    chk("rst_rd_data", {28'd0, rd_data}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_unlocked", {31'd0, unlocked}, 32'd0);
    chk("rst_alarm", {31'd0, alarm}, 32'd0);
    chk("rst_pulses", {28'd0, wr_err, unlock_ok, unlock_fail, rd_err}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; rd_addr = '0; unlock_req = 1'b0; key = '0;
    lock_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    #12;
    apply_reset();
    @(posedge clk); #1;

    // Factory defaults, back-to-back reads
    for (int i = 0; i < 4; i++) do_read(2'(i));
    tick();

    // Write while locked is rejected
    do_write(2'd1, 4'b0011);
    chk("locked_wr_err", {31'd0, wr_err}, 32'd1);
    do_read(2'd1);

    // Unlock, write, then idle timeout after 16 cycles
    do_unlock(4'b1100);
    chk("unlock_ok", {31'd0, unlock_ok}, 32'd1);
    chk("unlocked", {31'd0, unlocked}, 32'd1);
    do_write(2'd2, 4'b0101);
    chk("wr_err_ok", {31'd0, wr_err}, 32'd0);
    model_mem[2] = 4'b0101;
    do_read(2'd2);
    for (int i = 0; i < 14; i++) tick();
    chk("unlocked_15", {31'd0, unlocked}, 32'd1);
    tick();
    chk("unlocked_16", {31'd0, unlocked}, 32'd0);

    // Three bad keys -> lockout
    for (int i = 0; i < 3; i++) begin
      do_unlock(4'b0000);
      chk("unlock_fail", {31'd0, unlock_fail}, 32'd1);
      chk("alarm_ramp", {31'd0, alarm}, (i == 2) ? 32'd1 : 32'd0);
    end
    do_unlock(4'b1100);
    chk("lockout_ok", {31'd0, unlock_ok}, 32'd0);
    chk("lockout_fail", {31'd0, unlock_fail}, 32'd0);
    chk("lockout_unl", {31'd0, unlocked}, 32'd0);
    lock_req = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("alarm_31", {31'd0, alarm}, 32'd1);
    tick();
    chk("alarm_32", {31'd0, alarm}, 32'd0);
    do_unlock(4'b1100);
    chk("post_lockout_ok", {31'd0, unlock_ok}, 32'd1);

    // Password change takes effect immediately
    do_write(2'd0, 4'b0111);
    model_mem[0] = 4'b0111;
    lock_req = 1'b1;
    tick();
    chk("lock_req", {31'd0, unlocked}, 32'd0);
    do_unlock(4'b1100);
    chk("old_pw_fail", {31'd0, unlock_fail}, 32'd1);
    do_unlock(4'b0111);
    chk("new_pw_ok", {31'd0, unlock_ok}, 32'd1);
    chk("new_pw_unl", {31'd0, unlocked}, 32'd1);

    // Reset restores factory password
    apply_reset();
    @(posedge clk); #1;
    do_read(2'd0);

    // Same-cycle read/write returns old data
    do_unlock(4'b1100);
    chk("unlock2", {31'd0, unlocked}, 32'd1);
    rd_en = 1'b1; rd_addr = 2'd2;
    do_write(2'd2, 4'b1111);
    model_mem[2] = 4'b1111;
    do_read(2'd2);

    // unlock_req while unlocked is ignored
    do_unlock(4'b0000);
    chk("unl_ign_fail", {31'd0, unlock_fail}, 32'd0);
    chk("unl_ign_state", {31'd0, unlocked}, 32'd1);

    // lock_req beats a same-cycle write
    lock_req = 1'b1;
    do_write(2'd3, 4'b1001);
    chk("lock_wr_err", {31'd0, wr_err}, 32'd1);
    chk("lock_wr_state", {31'd0, unlocked}, 32'd0);
    do_read(2'd3);

    // Unlock evaluated, same-cycle write rejected in LOCKED
    unlock_req = 1'b1; key = 4'b1100;
    do_write(2'd1, 4'b0000);
    chk("unl_wr_ok", {31'd0, unlock_ok}, 32'd1);
    chk("unl_wr_err", {31'd0, wr_err}, 32'd1);
    do_read(2'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/limit_regfile.md
Name: limit_regfile

Overview:
- Parametrised, password-guarded register file for the home-security system's limit table: password, particle limit, temperature limit and room-cool limit.
- Each entry resets to a fixed factory default.
- Entries are readable at any time through a registered read port.
- Entries are writable only after an unlock handshake that matches the stored password in entry 0.
- Repeated failed unlock attempts raise an alarm and force a timed lockout.

Parameters:
- WIDTH, 4, bits per entry.
- DEPTH, 4, number of entries; entry 0 is always the password.
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH.
- INIT, 16'h68AC, DEPTH*WIDTH reset image; entry i = INIT[i*WIDTH +: WIDTH]. Default gives 1100, 1010, 1000, 0110.
- UNLOCK_CYCLES, 16, idle cycles before an unlocked file relocks.
- MAX_FAIL, 3, consecutive failed unlocks that trigger lockout.
- LOCKOUT_CYCLES, 32, lockout duration in cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  WIDTH  read result, registered.
- rd_valid  out  1  one-cycle pulse qualifying rd_data.
- rd_err  out  1  one-cycle pulse, read address >= DEPTH.
- unlock_req  in  1  unlock attempt strobe.
- key  in  WIDTH  candidate password, sampled with unlock_req.
- lock_req  in  1  immediate relock.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- wr_err  out  1  one-cycle pulse, write rejected.
- unlock_ok  out  1  one-cycle pulse, unlock accepted.
- unlock_fail  out  1  one-cycle pulse, unlock rejected.
- unlocked  out  1  high while in UNLOCKED.
- alarm  out  1  high while in LOCKOUT.

Behaviour:
- Reset (asynchronous assert):
  - Every entry reloads from INIT; state goes to LOCKED.
  - Timer and fail_cnt are cleared.
  - All outputs go to 0, including rd_data.
  - Reset mid-write or mid-unlock discards that operation. Programmed limits are lost by design.
- Read port:
  - rd_en at edge N gives rd_data/rd_valid at edge N+1 (one-cycle latency).
  - rd_data holds its value between reads.
  - Reads are accepted in every state.
  - Out-of-range read: rd_data = 0, rd_valid = 1, rd_err = 1.
  - Read and write to the same address in the same cycle return the OLD data.
- States:
  - LOCKED:
    - unlock_req with key == entry0: go to UNLOCKED, load timer = UNLOCK_CYCLES, clear fail_cnt, pulse unlock_ok.
    - Mismatch: fail_cnt+1, pulse unlock_fail. If the new fail_cnt == MAX_FAIL, go to LOCKOUT and load timer = LOCKOUT_CYCLES.
  - UNLOCKED:
    - Timer decrements each cycle with no accepted write.
    - An accepted write reloads the timer to UNLOCK_CYCLES.
    - Timer reaching 0 goes to LOCKED.
    - lock_req goes to LOCKED on the next edge and has priority over a same-cycle write; that write is dropped with wr_err.
    - unlock_req is ignored (no pulses).
  - LOCKOUT:
    - alarm = 1; unlock_req ignored with no fail counting.
    - Timer decrements. On 0: go to LOCKED, clear fail_cnt, drop alarm.
    - lock_req has no effect.
- Writes:
  - Accepted only in UNLOCKED with wr_addr < DEPTH; entry updates at that edge.
  - Otherwise pulse wr_err and leave memory unchanged.
  - Writing entry 0 changes the password immediately for all later unlock attempts. The session stays unlocked.
- Simultaneous events:
  - unlock_req and wr_en in LOCKED: evaluate the unlock; the write gets wr_err.
  - The key compare uses entry 0 as stored before any same-edge update.
- Widths:
  - Timer width is clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1).
  - fail_cnt width is clog2(MAX_FAIL+1) and saturates at MAX_FAIL.
- Storage is flops, not inferred RAM, so that per-entry asynchronous reset to INIT works.

Test Plan:
- Reset, then read addr 0..3 back-to-back: rd_data = 1100, 1010, 1000, 0110, each one cycle after rd_en; rd_err = 0.
- While LOCKED, write addr 1 = 0011: wr_err pulses; readback of addr 1 = 1010.
- unlock key = 1100: unlock_ok pulses and unlocked = 1. Then write addr 2 = 0101: readback 0101. Then 16 idle cycles: unlocked falls to 0.
- Three unlocks with key = 0000: unlock_fail ×3, alarm rises after the third. A correct key during lockout is ignored. After 32 cycles alarm = 0 and a correct key unlocks.
- Unlock, write addr 0 = 0111, lock_req: key 1100 then fails; key 0111 succeeds. Then reset: addr 0 reads 1100.
- Read addr 2 while writing addr 2 = 1111 in the same cycle: rd_data = old value, next read = 1111. Same-cycle lock_req + wr_en: wr_err pulses and no update.
